tile_row_reducer: RTL

- Sits directly downstream of pipeline_4array_top and consumes its final-array tile output (result_out_3 / valid_out).
- Each accepted TILE_SIZE x TILE_SIZE partial-product tile is reduced row-wise, and the row sums are accumulated over a configurable number of k-step beats.
- At the end of each row block it emits one TILE_SIZE-element vector, both at full precision and rescaled/saturated to fixed-point, over a valid/ready handshake.
- This makes row-block matrix-vector accumulation a hardware function.

---
 rtl/tile_row_reducer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tile_row_reducer.sv
// Row-wise reduction of partial-product tiles, accumulated over a configurable
// number of k-step beats, emitting full-precision and rescaled row totals.
module tile_row_reducer #(
    parameter int TILE_SIZE = 4,
    parameter int ACC_WIDTH = 32,
    parameter int SUM_WIDTH = 48,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8,
    parameter int BEATS_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BEATS_W-1:0]          beats_cfg,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] in_tile [TILE_SIZE][TILE_SIZE],
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [SUM_WIDTH-1:0] out_sum [TILE_SIZE],
    output logic signed [OUT_WIDTH-1:0] out_q [TILE_SIZE],
    output logic [TILE_SIZE-1:0]        out_sat,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic signed [SUM_WIDTH-1:0] Q_MAX =
        {{(SUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] Q_MIN = ~Q_MAX;

    function automatic logic signed [SUM_WIDTH-1:0] sext(input logic signed [ACC_WIDTH-1:0] a);
        return {{(SUM_WIDTH-ACC_WIDTH){a[ACC_WIDTH-1]}}, a};
    endfunction

    // Returns {saturated, value}.
    function automatic logic [OUT_WIDTH:0] rescale(input logic signed [SUM_WIDTH-1:0] a);
        logic signed [SUM_WIDTH-1:0] t;
        t = a >>> FRAC_BITS;
        if (t > Q_MAX)      return {1'b1, Q_MAX[OUT_WIDTH-1:0]};
        else if (t < Q_MIN) return {1'b1, Q_MIN[OUT_WIDTH-1:0]};
        else                return {1'b0, t[OUT_WIDTH-1:0]};
    endfunction

    state_t                      state_p1, state_nxt;
    logic signed [SUM_WIDTH-1:0] rs_p0   [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0] acc_p1  [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0] acc_nxt [TILE_SIZE];
    logic [BEATS_W-1:0]          count_p1, count_nxt;
    logic [BEATS_W-1:0]          beats_p1, beats_nxt;
    logic [BEATS_W-1:0]          beats_eff;
    logic                        accept, start, retire, load_q;

    // Stage p0: combinational row sums of the incoming tile
    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            rs_p0[i] = '0;
            for (int j = 0; j < TILE_SIZE; j++) begin
                rs_p0[i] = rs_p0[i] + sext(in_tile[i][j]);
            end
        end
    end

    assign beats_eff = (beats_cfg == '0) ? BEATS_W'(1) : beats_cfg;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    // A beat taken outside ACCUM always opens a fresh block.
    assign start     = accept & (state_p1 != ACCUM);
    assign load_q    = accept & (state_nxt == HOLD);

    always_ff @(posedge clk) begin
        if (rst) state_p1 <= IDLE;
        else     state_p1 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p1;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state_p1)
                IDLE, HOLD: begin
                    if (accept)
                        state_nxt = (beats_eff == BEATS_W'(1)) ? HOLD : ACCUM;
                    else if (state_p1 == HOLD && out_ready)
                        state_nxt = IDLE;
                end
                ACCUM: begin
                    if (accept && (count_p1 + BEATS_W'(1)) == beats_p1)
                        state_nxt = HOLD;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = ~flush & ((state_p1 != HOLD) | out_ready);
        out_valid = (state_p1 == HOLD);
        busy      = (state_p1 != IDLE);
    end

    always_comb begin
        acc_nxt   = acc_p1;
        count_nxt = count_p1;
        beats_nxt = beats_p1;
        if (flush) begin
            for (int i = 0; i < TILE_SIZE; i++) acc_nxt[i] = '0;
            count_nxt = '0;
        end else if (start) begin
            acc_nxt   = rs_p0;
            count_nxt = BEATS_W'(1);
            beats_nxt = beats_eff;
        end else if (accept) begin
            for (int i = 0; i < TILE_SIZE; i++) acc_nxt[i] = acc_p1[i] + rs_p0[i];
            count_nxt = count_p1 + BEATS_W'(1);
        end else if (retire) begin
            for (int i = 0; i < TILE_SIZE; i++) acc_nxt[i] = '0;
            count_nxt = '0;
        end
    end

    // Stage p1: accumulators and the rescaled result captured on HOLD entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TILE_SIZE; i++) begin
                acc_p1[i] <= '0;
                out_q[i]  <= '0;
            end
            out_sat  <= '0;
            count_p1 <= '0;
            beats_p1 <= '0;
        end else begin
            acc_p1   <= acc_nxt;
            count_p1 <= count_nxt;
            beats_p1 <= beats_nxt;
            if (load_q) begin
                for (int i = 0; i < TILE_SIZE; i++)
                    {out_sat[i], out_q[i]} <= rescale(acc_nxt[i]);
            end
        end
    end

    assign out_sum = acc_p1;

endmodule
